// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, 16x oversample factor,
// and the baud_select -> divisor table (divisor = CLK/(16*baud), rounded).
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned BAUD_CODES = 8;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned TICK_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned BAUD_RATE [BAUD_CODES] = '{
    300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Round-to-nearest divisor for one baud code; only ever called with constants.
  function automatic logic [31:0] div_for_code(input int unsigned clk_hz,
                                               input logic [2:0]  code);
    longint den;
    den = longint'(OVERSAMPLE) * longint'(BAUD_RATE[code]);
    return 32'((longint'(clk_hz) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// 16x oversample tick generator: one-cycle o_tick every divisor clocks for the
// selected baud code; i_clear restarts the count so the first tick is a full period away.
module baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_baud_select,
  input  logic       i_clear,
  output logic       o_tick
);

  logic [DIV_W-1:0] w_div_table [BAUD_CODES];
  logic [DIV_W-1:0] w_div_last;
  logic [DIV_W-1:0] r_cnt;

  for (genvar g = 0; g < BAUD_CODES; g++) begin : g_div
    assign w_div_table[g] = DIV_W'(div_for_code(CLK_FREQ_HZ, 3'(g)));
  end

  assign w_div_last = w_div_table[i_baud_select] - DIV_W'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == w_div_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign o_tick = ~i_clear & (r_cnt == w_div_last);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN for the 11-bit frame; otherwise frames are 10 bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       TxD,
  output logic       Tx_BUSY,
  output tx_state_e  o_dbg_state
);

  // Handshake: Tx_WR is valid, (Tx_EN & ~Tx_BUSY) is ready; a byte transfers on
  // a rising edge where both hold, otherwise the strobe is dropped (no queue).

  tx_state_e             r_state;
  tx_state_e             w_next_state;
  logic [7:0]            r_data;
  logic [2:0]            r_baud;
  logic [TICK_CNT_W-1:0] r_tick_cnt;
  logic [2:0]            r_bit_idx;
  logic                  w_tick;
  logic                  w_accept;
  logic                  w_abort;
  logic                  w_bit_done;

  assign w_accept   = Tx_WR & Tx_EN & (r_state == ST_IDLE);
  assign w_abort    = (r_state != ST_IDLE) & ~Tx_EN;
  assign w_bit_done = w_tick & (r_tick_cnt == TICK_CNT_W'(OVERSAMPLE - 1));

  baud_controller #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_baud (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_baud_select (r_baud),
    .i_clear       (w_accept),
    .o_tick        (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_START;
      ST_START:  if (w_bit_done) w_next_state = ST_DATA;
      ST_DATA: begin
        if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
      ST_PARITY: if (w_bit_done) w_next_state = ST_STOP;
      ST_STOP:   if (w_bit_done) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next_state = ST_IDLE;
    end
  end

  always_comb begin
    TxD     = 1'b1;
    Tx_BUSY = (r_state != ST_IDLE);
    case (r_state)
      ST_START:  TxD = 1'b0;
      ST_DATA:   TxD = r_data[r_bit_idx];
      ST_PARITY: TxD = ^r_data;
      default:   TxD = 1'b1;
    endcase
  end

  // Byte and rate are frozen at accept so mid-frame input changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_baud     <= '0;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (w_accept) begin
      r_data     <= Tx_DATA;
      r_baud     <= baud_select;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
    end else if ((r_state == ST_IDLE) || w_abort) begin
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + TICK_CNT_W'(1);
      if (w_bit_done && (r_state == ST_DATA)) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: reference model builds each frame
// as a bit list and a bit period from CLK/(16*baud) with real-valued rounding.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ = 3686400;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic       TxD;
  logic       Tx_BUSY;
  tx_state_e  dbg_state;

  int checks;
  int passes;
  logic exp_q[$];
  logic line_q[$];
  int rates [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  uart_transmitter #(
    .CLK_FREQ_HZ (CLK_HZ)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY),
    .o_dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic int model_period(input logic [2:0] sel);
    real r;
    r = real'(CLK_HZ) / (16.0 * real'(rates[sel]));
    return 16 * $rtoi(r + 0.5);
  endfunction

  function automatic void model_frame(input logic [7:0] data);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(data[i]);
      ones += int'(data[i]);
    end
`ifdef UART_TX_PARITY_EN
    exp_q.push_back((ones % 2) == 1);
`endif
    exp_q.push_back(1'b1);
  endfunction

  // Driver: record TxD each cycle while busy, optionally disturbing inputs mid-frame
  task automatic capture_frame(input int limit, input bit disturb, output int busy_cycles);
    line_q.delete();
    busy_cycles = 0;
    while ((Tx_BUSY === 1'b1) && (busy_cycles < limit)) begin
      line_q.push_back(TxD);
      Tx_WR = 1'b0;
      if (disturb && (busy_cycles % 97 == 5)) begin
        Tx_DATA     = 8'($urandom);
        baud_select = 3'($urandom_range(7, 0));
      end
      if (disturb && (busy_cycles == limit / 3)) begin
        Tx_DATA = 8'hFF;
        Tx_WR   = 1'b1;
      end
      @(negedge clk);
      busy_cycles++;
    end
    Tx_WR = 1'b0;
  endtask

  // Scenario: write one byte (caller is at a negedge) and check the whole frame
  task automatic test_frame(input string name, input logic [7:0] data,
                            input logic [2:0] sel, input bit disturb);
    int   p;
    int   n;
    int   busy;
    int   stable;
    logic level;
    p = model_period(sel);
    model_frame(data);
    n = exp_q.size();
    Tx_DATA     = data;
    baud_select = sel;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    capture_frame(n * p + 8, disturb, busy);
    checks++;
    if (busy !== n * p)
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy, n * p);
    else
      passes++;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (line_q.size() < (k + 1) * p) begin
        $display("FAIL %s bit%0d: got frame of %0d cycles expected at least %0d",
                 name, k, line_q.size(), (k + 1) * p);
      end else begin
        level  = line_q[k * p];
        stable = 1;
        for (int c = 1; c < p; c++) if (line_q[k * p + c] !== level) stable = 0;
        if ((level !== exp_q[k]) || (stable == 0))
          $display("FAIL %s bit%0d: got %b (stable=%0d) expected %b for %0d cycles",
                   name, k, level, stable, exp_q[k], p);
        else
          passes++;
      end
    end
    checks++;
    if ((TxD !== 1'b1) || (Tx_BUSY !== 1'b0))
      $display("FAIL %s idle_after: got TxD=%b busy=%b expected TxD=1 busy=0", name, TxD, Tx_BUSY);
    else
      passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (TxD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", TxD); else passes++;
    checks++;
    if (Tx_BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Tx_BUSY); else passes++;
    checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    else passes++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divisor_table();
    int exp_div [8] = '{20833, 5208, 1302, 651, 326, 163, 109, 54};
    int got;
    for (int s = 0; s < 8; s++) begin
      got = int'(div_for_code(32'd100000000, 3'(s)));
      checks++;
      if (got !== exp_div[s]) $display("FAIL divisor_code%0d: got %0d expected %0d", s, got, exp_div[s]);
      else passes++;
    end
  endtask

  task automatic test_known_frame();
    test_frame("known_0x89_sel7", 8'h89, 3'd7, 1'b0);
  endtask

  task automatic test_zero_parity();
    test_frame("zero_0x00_sel3", 8'h00, 3'd3, 1'b0);
  endtask

  task automatic test_disabled_write();
    int bad;
    bad   = 0;
    Tx_EN = 1'b0;
    Tx_DATA = 8'h3C;
    baud_select = 3'd7;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat (40) begin
      if ((Tx_BUSY !== 1'b0) || (TxD !== 1'b1)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) $display("FAIL disabled_write: got %0d busy cycles expected 0", bad); else passes++;
    Tx_EN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    test_frame("first_0x89_with_ignored_write", 8'h89, 3'd7, 1'b1);
    test_frame("next_0xFF", 8'hFF, 3'd7, 1'b0);
  endtask

  task automatic test_enable_abort();
    int         p;
    int         bad;
    logic [7:0] data;
    data = 8'hA5;
    p    = model_period(3'd7);
    Tx_DATA = data;
    baud_select = 3'd7;
    Tx_EN = 1'b1;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat (4 * p + p / 2) @(negedge clk);
    checks++;
    if ((TxD !== data[3]) || (Tx_BUSY !== 1'b1))
      $display("FAIL abort_pre: got TxD=%b busy=%b expected TxD=%b busy=1", TxD, Tx_BUSY, data[3]);
    else
      passes++;
    Tx_EN = 1'b0;
    @(negedge clk);
    checks++;
    if ((TxD !== 1'b1) || (Tx_BUSY !== 1'b0) || (dbg_state !== ST_IDLE))
      $display("FAIL abort_next: got TxD=%b busy=%b state=%0d expected 1 0 %0d",
               TxD, Tx_BUSY, dbg_state, ST_IDLE);
    else
      passes++;
    bad = 0;
    repeat (3 * p) begin
      @(negedge clk);
      if ((TxD !== 1'b1) || (Tx_BUSY !== 1'b0)) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); else passes++;
    Tx_EN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stop();
    int p;
    p = model_period(3'd7);
    Tx_DATA = 8'h55;
    baud_select = 3'd7;
    Tx_EN = 1'b1;
    Tx_WR = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    repeat ((FRAME_BITS - 1) * p + p / 2) @(negedge clk);
    checks++;
    if ((TxD !== 1'b1) || (Tx_BUSY !== 1'b1))
      $display("FAIL stop_pre: got TxD=%b busy=%b expected TxD=1 busy=1", TxD, Tx_BUSY);
    else
      passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ((TxD !== 1'b1) || (Tx_BUSY !== 1'b0) || (dbg_state !== ST_IDLE))
      $display("FAIL async_reset: got TxD=%b busy=%b state=%0d expected 1 0 %0d",
               TxD, Tx_BUSY, dbg_state, ST_IDLE);
    else
      passes++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_frame("after_reset_0x55", 8'h55, 3'd7, 1'b0);
  endtask

  task automatic test_random_frames();
    logic [7:0] data;
    logic [2:0] sel;
    bit         disturb;
    for (int i = 0; i < 6; i++) begin
      data    = 8'($urandom);
      sel     = 3'($urandom_range(7, 3));
      disturb = 1'($urandom_range(1, 0));
      test_frame($sformatf("random%0d_0x%02h_sel%0d", i, data, sel), data, sel, disturb);
    end
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    reset       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'd0;
    Tx_EN       = 1'b0;
    Tx_WR       = 1'b0;
    test_reset();
    test_divisor_table();
    test_known_frame();
    test_zero_parity();
    test_disabled_write();
    test_back_to_back();
    test_enable_abort();
    test_reset_mid_stop();
    test_random_frames();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000; system clock frequency, used to derive the baud divisors.
REQ-002 Port clk, input, 1 bit; the single clock, with all logic on its rising edge.
REQ-003 Port reset, input, 1 bit; asynchronous, active-high reset.
REQ-004 Port Tx_DATA, input, 8 bits; byte to send, sampled on accept.
REQ-005 Port baud_select, input, 3 bits; rate code, sampled on accept.
REQ-006 Port Tx_EN, input, 1 bit; transmitter enable.
REQ-007 Port Tx_WR, input, 1 bit; single-cycle write strobe.
REQ-008 Port TxD, output, 1 bit; serial line, idle high.
REQ-009 Port Tx_BUSY, output, 1 bit; high while a frame is in flight.

Function
REQ-010 The block SHALL derive a 16x sample-enable tick from baud_select using divisors 000:20833 (300), 001:5208 (1200), 010:1302 (4800), 011:651 (9600), 100:326 (19200), 101:163 (38400), 110:109 (57600), 111:54 (115200), each computed as CLK_FREQ_HZ/(16*baud) and rounded.
REQ-011 A write SHALL be accepted on a rising edge where Tx_WR=1, Tx_EN=1 and Tx_BUSY=0; Tx_DATA and baud_select are latched at that edge.
REQ-012 Tx_WR while Tx_BUSY=1 or Tx_EN=0 SHALL be ignored, with no queuing.
REQ-013 On accept, the tick counter SHALL be cleared; Tx_BUSY=1 and TxD=0 from the next cycle.
REQ-014 The FSM SHALL have states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; each non-IDLE state holds for exactly 16 ticks.
REQ-015 DATA SHALL shift out 8 bits LSB first, using a 3-bit index that wraps after bit 7 into PARITY.
REQ-016 PARITY SHALL drive the XOR of the 8 latched data bits (even parity).
REQ-017 STOP SHALL drive TxD=1; Tx_BUSY SHALL fall on the cycle the FSM returns to IDLE.
REQ-018 Tx_WR accepted on the same edge Tx_BUSY falls is impossible by REQ-011; the earliest next accept is the cycle after Tx_BUSY=0.
REQ-019 Tx_EN falling mid-frame SHALL abort the frame: the FSM goes to IDLE, TxD=1 and Tx_BUSY=0 on the next cycle.
REQ-020 Changes on baud_select or Tx_DATA mid-frame SHALL have no effect on the current frame.
REQ-021 Frame length SHALL be 11 bit periods of 16*divisor clocks each, with no jitter.

Reset
REQ-022 While reset=1, outputs SHALL be TxD=1 and Tx_BUSY=0, the FSM SHALL be IDLE, and all counters and data latches SHALL be 0, asynchronously.
REQ-023 Reset mid-frame SHALL drop the frame immediately; after release, the block SHALL accept a new write one cycle later.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined SHALL include the PARITY state (11-bit frame).
REQ-025 With UART_TX_PARITY_EN undefined, DATA SHALL go directly to STOP, giving a 10-bit frame and a Tx_BUSY period of 10 bit periods.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state encoding, the divisor table indexed by baud_select, and the constant 16 for oversample.
REQ-027 Sub-module baud_controller SHALL take reset, clk, baud_select and a synchronous clear, and output the single-cycle tick; it is reused by the receiver.

Verification
REQ-028 Reset, Tx_EN=1, baud_select=111, Tx_WR with Tx_DATA=0x89 -> TxD=0,1,0,0,1,0,0,0,1,1(parity),1(stop), each held 8640 ns at 100 MHz; Tx_BUSY high for 95040 ns.
REQ-029 Tx_DATA=0x00 at baud_select=011 -> parity bit 0, bit period 104160 ns, TxD idle high after the stop bit.
REQ-030 Second Tx_WR of 0xFF during a frame -> ignored, first frame unchanged; Tx_WR the cycle after Tx_BUSY falls -> 0xFF sent.
REQ-031 Tx_EN deasserted during DATA bit 3 -> TxD=1 and Tx_BUSY=0 the next cycle; no further transitions.
REQ-032 reset pulsed mid-STOP -> TxD=1 and Tx_BUSY=0 without waiting for a clock edge; a new write of 0x55 then produces a clean frame.
REQ-033 Build without UART_TX_PARITY_EN, 0x89 at 111 -> 10-bit frame, Tx_BUSY high for 86400 ns.
